// File: rtl/temp_classifier_if.sv
// Temperature sample / state-code bundle between a sensor front end and the classifier.
interface temp_classifier_if #(
  parameter int TEMP_W = 12
) ();
  logic              temp_valid;
  logic [TEMP_W-1:0] temp_data;
  logic [1:0]        temp_state;
  logic              state_change;
  logic              sensor_timeout;

  // Sample source side: drives samples, observes the classified state.
  modport master (
    output temp_valid,
    output temp_data,
    input  temp_state,
    input  state_change,
    input  sensor_timeout
  );

  // Classifier side: consumes samples, produces the state code.
  modport slave (
    input  temp_valid,
    input  temp_data,
    output temp_state,
    output state_change,
    output sensor_timeout
  );
endinterface

// File: rtl/temp_classifier.sv
// Temperature classifier: threshold hysteresis, debounced state changes,
// immediate FAULT on over-temperature and a sensor-loss watchdog.
module temp_classifier #(
  parameter int TEMP_W      = 12,
  parameter int T_NORMAL    = 200,
  parameter int T_WARN      = 600,
  parameter int T_FAULT     = 900,
  parameter int HYST        = 16,
  parameter int DEBOUNCE    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  temp_classifier_if.slave   tc_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NORMAL  = 2'd1,
    ST_WARNING = 2'd2,
    ST_FAULT   = 2'd3
  } tstate_e;

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TEMP_W-1:0] UP_N = TEMP_W'(T_NORMAL);
  localparam logic [TEMP_W-1:0] UP_W = TEMP_W'(T_WARN);
  localparam logic [TEMP_W-1:0] UP_F = TEMP_W'(T_FAULT);
  localparam logic [TEMP_W-1:0] DN_N = TEMP_W'(T_NORMAL - HYST);
  localparam logic [TEMP_W-1:0] DN_W = TEMP_W'(T_WARN - HYST);
  localparam logic [TEMP_W-1:0] DN_F = TEMP_W'(T_FAULT - HYST);
  localparam logic [CNT_W-1:0]  DEB_V  = CNT_W'(DEBOUNCE);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYC);

  // Number of thresholds (0..3) that the sample meets or exceeds.
  function automatic logic [1:0] level_of(
    input logic [TEMP_W-1:0] t,
    input logic [TEMP_W-1:0] a,
    input logic [TEMP_W-1:0] b,
    input logic [TEMP_W-1:0] c
  );
    level_of = {1'b0, (t >= a)} + {1'b0, (t >= b)} + {1'b0, (t >= c)};
  endfunction

  tstate_e           state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              tmo_q, tmo_d;
  logic              chg_q;

  logic [1:0]        c_up_s;
  logic [1:0]        c_dn_s;
  logic [1:0]        cand_s;
  logic [CNT_W-1:0]  run_s;
  logic [WD_W-1:0]   wd_inc_s;

  // Candidate class: rise on the up thresholds, fall only below threshold minus hysteresis.
  always_comb begin
    c_up_s = level_of(tc_bus.temp_data, UP_N, UP_W, UP_F);
    c_dn_s = level_of(tc_bus.temp_data, DN_N, DN_W, DN_F);
    if (c_up_s > state_q) begin
      cand_s = c_up_s;
    end else if (c_dn_s < state_q) begin
      cand_s = c_dn_s;
    end else begin
      cand_s = state_q;
    end
    if ((cnt_q != {CNT_W{1'b0}}) && (cand_s == pend_q)) begin
      run_s = cnt_q + CNT_W'(1);
    end else begin
      run_s = CNT_W'(1);
    end
    wd_inc_s = wdog_q + WD_W'(1);
  end

  // Next-state: valid samples drive debounce/bypass and kick the watchdog; idle cycles age it.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
    if (tc_bus.temp_valid) begin
      wdog_d = {WD_W{1'b0}};
      tmo_d  = 1'b0;
      if (c_up_s == 2'd3) begin
        state_d = ST_FAULT;
        cnt_d   = {CNT_W{1'b0}};
      end else if (cand_s == state_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        pend_d = cand_s;
        if (run_s >= DEB_V) begin
          state_d = tstate_e'(cand_s);
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = run_s;
        end
      end
    end else if (wdog_q != WD_MAX) begin
      wdog_d = wd_inc_s;
      if (wd_inc_s == WD_MAX) begin
        state_d = ST_FAULT;
        tmo_d   = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        tmo_d = tmo_q;
      end
    end else begin
      wdog_d = wdog_q;
    end
  end

  // State, debounce, watchdog and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 2'd0;
      cnt_q   <= {CNT_W{1'b0}};
      wdog_q  <= {WD_W{1'b0}};
      tmo_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
      chg_q   <= (state_d != state_q);
    end
  end

  assign tc_bus.temp_state     = state_q;
  assign tc_bus.state_change   = chg_q;
  assign tc_bus.sensor_timeout = tmo_q;

endmodule

// File: tb/tb_temp_classifier.sv
// Self-checking bench for temp_classifier: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_temp_classifier;
  localparam int TEMP_W      = 12;
  localparam int T_NORMAL    = 200;
  localparam int T_WARN      = 600;
  localparam int T_FAULT     = 900;
  localparam int HYST        = 16;
  localparam int DEBOUNCE    = 4;
  localparam int TIMEOUT_CYC = 1000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  temp_classifier_if #(.TEMP_W(TEMP_W)) tb_if ();

  temp_classifier #(
    .TEMP_W(TEMP_W), .T_NORMAL(T_NORMAL), .T_WARN(T_WARN), .T_FAULT(T_FAULT),
    .HYST(HYST), .DEBOUNCE(DEBOUNCE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tc_bus(tb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_state, m_pend, m_cnt, m_wd, m_tmo, m_chg;
  int thr[3];

  function automatic int count_ge(input int t, input int off);
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) if (t >= thr[i] - off) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pend = 0; m_cnt = 0; m_wd = 0; m_tmo = 0; m_chg = 0;
  endtask

  task automatic model_step(input bit v, input int d);
    int prev, up, dn, cand;
    prev = m_state;
    if (v) begin
      m_wd = 0;
      m_tmo = 0;
      up = count_ge(d, 0);
      dn = count_ge(d, HYST);
      cand = (up > m_state) ? up : ((dn < m_state) ? dn : m_state);
      if (up == 3) begin
        m_state = 3;
        m_cnt = 0;
      end else if (cand == m_state) begin
        m_cnt = 0;
      end else begin
        if (m_cnt > 0 && cand == m_pend) m_cnt++;
        else begin
          m_pend = cand;
          m_cnt = 1;
        end
        if (m_cnt >= DEBOUNCE) begin
          m_state = m_pend;
          m_cnt = 0;
        end
      end
    end else if (m_wd < TIMEOUT_CYC) begin
      m_wd++;
      if (m_wd == TIMEOUT_CYC) begin
        m_state = 3;
        m_tmo = 1;
        m_cnt = 0;
      end
    end
    m_chg = (m_state != prev) ? 1 : 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, {30'd0, tb_if.temp_state}, m_state);
    check({tag, ".chg"}, {31'd0, tb_if.state_change}, m_chg);
    check({tag, ".tmo"}, {31'd0, tb_if.sensor_timeout}, m_tmo);
  endtask

  task automatic step(input bit v, input int d, input string tag);
    @(negedge clk);
    tb_if.temp_valid = v;
    tb_if.temp_data  = TEMP_W'(d);
    model_step(v, d);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic steps(input int n, input bit v, input int d, input string tag);
    for (int i = 0; i < n; i++) step(v, d, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tb_if.temp_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int vals[12];
    int d;
    bit v;
    checks = 0;
    errors = 0;
    thr[0] = T_NORMAL; thr[1] = T_WARN; thr[2] = T_FAULT;
    vals = '{100, 190, 200, 250, 580, 590, 600, 650, 880, 890, 900, 950};
    reset = 1'b1;
    tb_if.temp_valid = 1'b0;
    tb_if.temp_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("por");
    @(negedge clk);
    reset = 1'b0;

    // 1: IDLE -> NORMAL after 4 samples of 250
    steps(3, 1'b1, 250, "t1");
    check("t1_hold", {30'd0, tb_if.temp_state}, 32'd0);
    step(1'b1, 250, "t1");
    check("t1_normal", {30'd0, tb_if.temp_state}, 32'd1);
    check("t1_pulse", {31'd0, tb_if.state_change}, 32'd1);
    step(1'b0, 0, "t1");
    check("t1_pulse_end", {31'd0, tb_if.state_change}, 32'd0);

    // 2: 590 restarts the WARNING debounce
    steps(3, 1'b1, 650, "t2");
    step(1'b1, 590, "t2");
    steps(3, 1'b1, 650, "t2");
    check("t2_hold", {30'd0, tb_if.temp_state}, 32'd1);
    step(1'b1, 650, "t2");
    check("t2_warn", {30'd0, tb_if.temp_state}, 32'd2);

    // 3: hysteresis band holds WARNING, 580 drops to NORMAL
    steps(8, 1'b1, 590, "t3");
    check("t3_hyst", {30'd0, tb_if.temp_state}, 32'd2);
    steps(3, 1'b1, 580, "t3");
    check("t3_hold", {30'd0, tb_if.temp_state}, 32'd2);
    step(1'b1, 580, "t3");
    check("t3_normal", {30'd0, tb_if.temp_state}, 32'd1);

    // 4: FAULT bypass and hysteretic exit
    step(1'b1, 950, "t4");
    check("t4_fault", {30'd0, tb_if.temp_state}, 32'd3);
    steps(4, 1'b1, 890, "t4");
    check("t4_hyst", {30'd0, tb_if.temp_state}, 32'd3);
    steps(4, 1'b1, 880, "t4");
    check("t4_warn", {30'd0, tb_if.temp_state}, 32'd2);

    // 5: watchdog
    steps(TIMEOUT_CYC - 1, 1'b0, 0, "t5");
    check("t5_pre_tmo", {31'd0, tb_if.sensor_timeout}, 32'd0);
    step(1'b0, 0, "t5");
    check("t5_tmo", {31'd0, tb_if.sensor_timeout}, 32'd1);
    check("t5_fault", {30'd0, tb_if.temp_state}, 32'd3);
    steps(3, 1'b0, 0, "t5");
    check("t5_sat", {31'd0, tb_if.sensor_timeout}, 32'd1);
    step(1'b1, 100, "t5");
    check("t5_tmo_clr", {31'd0, tb_if.sensor_timeout}, 32'd0);
    check("t5_still_fault", {30'd0, tb_if.temp_state}, 32'd3);
    steps(3, 1'b1, 100, "t5");
    check("t5_idle", {30'd0, tb_if.temp_state}, 32'd0);

    // 6: reset mid-debounce discards progress
    steps(2, 1'b1, 250, "t6");
    do_reset();
    check("t6_reset", {30'd0, tb_if.temp_state}, 32'd0);
    steps(3, 1'b1, 250, "t6");
    check("t6_hold", {30'd0, tb_if.temp_state}, 32'd0);
    step(1'b1, 250, "t6");
    check("t6_normal", {30'd0, tb_if.temp_state}, 32'd1);

    // Random traffic around the thresholds, gaps and one long sensor loss
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) d = $urandom % 4096;
      else d = vals[$urandom % 12] + int'($urandom % 5) - 2;
      step(v, d, "rnd");
      if (i == 1500) steps(TIMEOUT_CYC + 5, 1'b0, 0, "rnd_wd");
      if (i == 2500) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout bench did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
